// File: rtl/chip_pkg.sv
// Shared definitions for the dual compute-unit chip: the instruction word layout
// and the encoding of the byte-assembler states.
package chip_pkg;

  localparam int unsigned INSTR_W  = 16;

  // Instruction fields. The loader itself only decodes UNIT_BIT.
  localparam int unsigned UNIT_BIT = 15;
  localparam int unsigned OPC_MSB  = 14;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned REG_MSB  = 11;
  localparam int unsigned REG_LSB  = 8;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;

  // Assembler state: HI waits for the high byte, LO for the low byte.
  typedef enum logic [0:0] {
    ASM_HI = 1'b0,
    ASM_LO = 1'b1
  } asm_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an asynchronously reset storage array.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i, wdata_i write request and data; accepted when not full, or when full
//                   together with a pop (the pop frees the slot first)
//   pop_i           read request; ignored when empty
//   rdata_o         head entry; when empty, the most recently popped entry
//                   (all zero after reset)
//   full_o, empty_o status flags
//   level_o         number of entries held, 0..Depth
module sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned LevelW = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [Width-1:0]  mem_d [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              wr_en, rd_en;

  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  // While empty the slot behind rd_ptr still holds the last popped entry and
  // cannot be overwritten (writes land at wr_ptr == rd_ptr), so the output
  // holds its last value without an extra register.
  assign rdata_o = empty_o ? mem_q[rd_ptr_q - PtrW'(1)] : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    level_d = level_q + LevelW'(wr_en) - LevelW'(rd_en);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/instr_byte_loader.sv
// Instruction byte loader: assembles 16-bit instructions from pairs of input
// bytes (high byte first), buffers them in a FIFO and dispatches the head to
// compute unit 0 or 1 according to bit 15, using a valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ena                    block enable; when low, strobes are ignored and no
//                          dispatch occurs
//   byte_in, byte_stb      instruction byte and its per-cycle valid
//   frame_rst              resync: assembler back to the high-byte state
//   cu0_valid/cu0_ready    handshake toward compute unit 0
//   cu1_valid/cu1_ready    handshake toward compute unit 1
//   instr_out              head instruction, shared by both units
//   fifo_level             entries held
//   overflow               sticky: an instruction was dropped on a full FIFO
//
// Optional feature macro INSTR_STATS_EN adds:
//   dispatch_cnt           wrapping count of dispatched instructions
//   last_unit              unit bit of the last dispatched instruction
module instr_byte_loader
  import chip_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         byte_in,
  input  logic               byte_stb,
  input  logic               frame_rst,
  output logic               cu0_valid,
  output logic               cu1_valid,
  input  logic               cu0_ready,
  input  logic               cu1_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PTR_W:0]     fifo_level,
`ifdef INSTR_STATS_EN
  output logic [7:0]         dispatch_cnt,
  output logic [0:0]         last_unit,
`endif
  output logic               overflow
);

  asm_state_e   state_q, state_d;
  logic [7:0]   hi_q, hi_d;
  logic         overflow_q, overflow_d;

  logic         stb;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic         head_unit;

  assign stb = byte_stb && ena;

  // Byte assembler. frame_rst wins over a strobe in the same cycle.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    push    = 1'b0;
    if (frame_rst) begin
      state_d = ASM_HI;
      hi_d    = '0;
    end else if (stb) begin
      unique case (state_q)
        ASM_HI: begin
          hi_d    = byte_in;
          state_d = ASM_LO;
        end
        ASM_LO: begin
          push    = 1'b1;
          state_d = ASM_HI;
        end
      endcase
    end
  end

  sync_fifo #(
    .Width (INSTR_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i ({hi_q, byte_in}),
    .pop_i   (pop),
    .rdata_o (instr_out),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  // Dispatch: only the unit selected by the head's unit bit sees valid, so
  // only that unit's ready can pop.
  assign head_unit = instr_out[UNIT_BIT];
  assign cu0_valid = !empty && ena && !head_unit;
  assign cu1_valid = !empty && ena && head_unit;
  assign pop       = (cu0_valid && cu0_ready) || (cu1_valid && cu1_ready);

  // A push on a full FIFO without a pop in the same cycle is dropped.
  assign overflow_d = overflow_q || (push && full && !pop);
  assign overflow   = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ASM_HI;
      hi_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef INSTR_STATS_EN
  logic [7:0] dispatch_cnt_q, dispatch_cnt_d;
  logic       last_unit_q, last_unit_d;

  always_comb begin
    dispatch_cnt_d = dispatch_cnt_q;
    last_unit_d    = last_unit_q;
    if (pop) begin
      dispatch_cnt_d = dispatch_cnt_q + 8'd1;
      last_unit_d    = head_unit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispatch_cnt_q <= '0;
      last_unit_q    <= 1'b0;
    end else begin
      dispatch_cnt_q <= dispatch_cnt_d;
      last_unit_q    <= last_unit_d;
    end
  end

  assign dispatch_cnt = dispatch_cnt_q;
  assign last_unit    = last_unit_q;
`endif

endmodule

// File: tb/tb_instr_byte_loader.sv
// Scoreboard bench for instr_byte_loader: stimulus pushes expected instructions
// into a queue; a monitor pops and compares on every accepted dispatch and also
// checks that a pending valid stays high with a stable instruction.
module tb_instr_byte_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_stb = 1'b0;
  logic        frame_rst = 1'b0;
  logic        cu0_valid, cu1_valid;
  logic        cu0_ready = 1'b0;
  logic        cu1_ready = 1'b0;
  logic [15:0] instr_out;
  logic [2:0]  fifo_level;
  logic        overflow;
`ifdef INSTR_STATS_EN
  logic [7:0]  dispatch_cnt;
  logic [0:0]  last_unit;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  instr_byte_loader #(
    .DEPTH (4),
    .PTR_W (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .byte_in    (byte_in),
    .byte_stb   (byte_stb),
    .frame_rst  (frame_rst),
    .cu0_valid  (cu0_valid),
    .cu1_valid  (cu1_valid),
    .cu0_ready  (cu0_ready),
    .cu1_ready  (cu1_ready),
    .instr_out  (instr_out),
    .fifo_level (fifo_level),
`ifdef INSTR_STATS_EN
    .dispatch_cnt (dispatch_cnt),
    .last_unit    (last_unit),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted dispatch against the scoreboard queue.
  logic        prev_pending = 1'b0;
  logic [15:0] prev_instr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pending = 1'b0;
    end else begin
      logic valid_any, taken;
      valid_any = cu0_valid || cu1_valid;
      taken = (cu0_valid && cu0_ready) || (cu1_valid && cu1_ready);
      if (cu0_valid && cu1_valid) check("both_valid", 32'(cu1_valid), 32'd0);
      if (prev_pending && ena) begin
        check("valid_held", 32'(valid_any), 32'd1);
        check("instr_stable", 32'(instr_out), 32'(prev_instr));
      end
      if (taken) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dispatch", 32'(instr_out), 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("dispatch_instr", 32'(instr_out), 32'(e));
          check("dispatch_unit", 32'(cu1_valid), 32'(e[15]));
        end
      end
      prev_pending = valid_any && !taken;
      prev_instr   = instr_out;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    byte_in  = b;
    byte_stb = 1'b1;
    @(posedge clk); #1;
    byte_stb = 1'b0;
  endtask

  task automatic send_instr(input logic [15:0] w, input bit kept);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    if (kept) exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (fifo_level != 0 && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(fifo_level), 32'd0);
    check({name, "_queue"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    do_reset();
    ena = 1'b1;
    check("rst_cu0_valid", 32'(cu0_valid), 0);
    check("rst_cu1_valid", 32'(cu1_valid), 0);
    check("rst_instr", 32'(instr_out), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Simple CU0 dispatch, popped on the first valid cycle.
    cu0_ready = 1'b1;
    send_instr(16'h1234, 1'b1);
    check("t1_cu0_valid", 32'(cu0_valid), 1);
    check("t1_cu1_valid", 32'(cu1_valid), 0);
    check("t1_instr", 32'(instr_out), 32'h1234);
    check("t1_level", 32'(fifo_level), 1);
    tick();
    check("t1_level_after", 32'(fifo_level), 0);
    check("t1_valid_after", 32'(cu0_valid), 0);
    check("t1_instr_hold", 32'(instr_out), 32'h1234);
    cu0_ready = 1'b0;

    // Enable low: strobes ignored.
    ena = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    check("ena_low_level", 32'(fifo_level), 0);
    ena = 1'b1;

    // CU1 held off for three cycles.
    send_instr(16'h85AA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t2_cu1_valid", 32'(cu1_valid), 1);
      check("t2_cu0_valid", 32'(cu0_valid), 0);
      check("t2_instr", 32'(instr_out), 32'h85AA);
      tick();
    end
    cu1_ready = 1'b1;
    check("t2_cu1_valid_last", 32'(cu1_valid), 1);
    tick();
    cu1_ready = 1'b0;
    check("t2_done_valid", 32'(cu1_valid), 0);
    check("t2_done_level", 32'(fifo_level), 0);

    // Overflow: five pushes into four entries, fifth dropped.
    send_instr(16'h0101, 1'b1);
    send_instr(16'h8202, 1'b1);
    send_instr(16'h0303, 1'b1);
    send_instr(16'h8404, 1'b1);
    check("t3_level_full", 32'(fifo_level), 4);
    check("t3_no_overflow_yet", 32'(overflow), 0);
    send_instr(16'h0505, 1'b0);
    check("t3_level", 32'(fifo_level), 4);
    check("t3_overflow", 32'(overflow), 1);
    check("t3_head", 32'(instr_out), 32'h0101);
    cu0_ready = 1'b1;
    cu1_ready = 1'b1;
    wait_empty("t3_drain");
    check("t3_overflow_sticky", 32'(overflow), 1);
    cu0_ready = 1'b0;
    cu1_ready = 1'b0;

    // Frame resync: 0x12 discarded; a strobe alongside frame_rst is ignored.
    do_reset();
    cu0_ready = 1'b1;
    send_byte(8'h12);
    frame_rst = 1'b1;
    send_byte(8'h99);
    frame_rst = 1'b0;
    send_instr(16'h5678, 1'b1);
    check("t4_instr", 32'(instr_out), 32'h5678);
    wait_empty("t4_drain");
    cu0_ready = 1'b0;

    // Full FIFO: LO strobe and head pop in the same cycle.
    send_instr(16'h0A01, 1'b1);
    send_instr(16'h8A02, 1'b1);
    send_instr(16'h0A03, 1'b1);
    send_instr(16'h8A04, 1'b1);
    check("t5_level_full", 32'(fifo_level), 4);
    send_byte(8'h0A);
    byte_in   = 8'h05;
    byte_stb  = 1'b1;
    cu0_ready = 1'b1;
    tick();
    byte_stb  = 1'b0;
    cu0_ready = 1'b0;
    exp_q.push_back(16'h0A05);
    check("t5_level", 32'(fifo_level), 4);
    check("t5_overflow", 32'(overflow), 0);
    check("t5_head", 32'(instr_out), 32'h8A02);
    cu0_ready = 1'b1;
    cu1_ready = 1'b1;
    wait_empty("t5_drain");
    cu0_ready = 1'b0;
    cu1_ready = 1'b0;

    // Asynchronous reset mid-instruction with three entries held.
    send_instr(16'h8C01, 1'b1);
    send_instr(16'h0C02, 1'b1);
    send_instr(16'h0C03, 1'b1);
    send_byte(8'h77);
    check("t6_level_pre", 32'(fifo_level), 3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_cu0_valid", 32'(cu0_valid), 0);
    check("t6_cu1_valid", 32'(cu1_valid), 0);
    check("t6_instr", 32'(instr_out), 0);
    check("t6_level", 32'(fifo_level), 0);
    check("t6_overflow", 32'(overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();
    cu1_ready = 1'b1;
    send_instr(16'h9ABC, 1'b1);
    check("t6_fresh_instr", 32'(instr_out), 32'h9ABC);
    wait_empty("t6_drain");
    cu1_ready = 1'b0;

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
